multu_seq: RTL and testbench
============================

# multu_seq

Iterative 32×32 unsigned shift-add multiplier that computes the product feeding the HI/LO pair of the single-cycle MIPS datapath. It replaces the combinational `multu` path with a sequential unit: operands are accepted on a `start` pulse, one partial product is accumulated per cycle, and the 64-bit result is split into `hi`/`lo` outputs that hold until the next completed operation. The datapath uses `busy` to stall the PC, and `done` as the HI/LO register write enable.

## Interface
- `WIDTH`, 32: operand width. The product is 2·`WIDTH` bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request a new multiply. Sampled only when `busy`=0.
- `srca` in `WIDTH`: multiplicand (rs), unsigned.
- `srcb` in `WIDTH`: multiplier (rt), unsigned.
- `busy` out 1: high while an operation is in progress (state RUN).
- `done` out 1: one-cycle pulse when `hi`/`lo` have just been updated.
- `hi` out `WIDTH`: upper half of the last completed product.
- `lo` out `WIDTH`: lower half of the last completed product.

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE. On reset, `busy`=0, `done`=0, `hi`=0, `lo`=0, the counter is 0 and the working registers are 0.
- IDLE or DONE with `start`=1:
  - Latch `srca` into the multiplicand register `mcand`.
  - Load product register `P[2W:0]` = {(W+1)'b0, `srcb`}.
  - Set counter = `WIDTH`, go to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each edge:
  - If `P[0]`=1, then `P[2W:W]` += {1'b0, `mcand`}, using W+1 bits so the carry is kept.
  - Then `P` is logically shifted right by 1.
  - Counter decrements by 1.
- RUN when the counter is 1 on the edge (the last iteration):
  - Perform the final iteration.
  - Write {`hi`,`lo`} = the resulting `P[2W-1:0]`.
  - Go to DONE.
- `start` during RUN is ignored. The operands in flight are unaffected, and the request is not queued.
- `hi`/`lo` change only on the completing edge. They hold the previous result throughout RUN, and they also hold across IDLE and DONE.
- No early termination: zero operands still take `WIDTH` iterations.
- Arithmetic is unsigned only. Bit 2W of `P` must be 0 after the final shift, and the result is exact modulo 2^(2W).
- `reset` asserted mid-RUN: the operation is aborted, outputs return to their reset values, and no `done` pulse occurs.

## Timing
- E0 is the edge on which `start` is sampled. `busy`=1 from E0 until E_WIDTH.
- Result edge: `hi`/`lo` are valid after edge E_WIDTH (E32 for the default). `done`=1 for exactly the one cycle following E_WIDTH.
- Total latency is `WIDTH` cycles from the start edge to valid results.
- Back-to-back operation: `start`=1 during the DONE cycle launches the next operation at E_WIDTH+1. Throughput is therefore one result every `WIDTH`+1 cycles.
- `busy` and `done` are registered state decodes with no combinational path from inputs: `busy` = (state==RUN), `done` = (state==DONE).
- `srca`/`srcb` need only be stable at E0.

## Structure
- Shared package `mips_pkg`:
  - Constant `MUL_WIDTH`=32.
  - State enum `mul_state_t` {IDLE, RUN, DONE} with 2-bit encoding.
  - Counter width constant `$clog2(MUL_WIDTH+1)`.
- One sub-module, `mul_step`: combinational single iteration, mapping (`P`, `mcand`) to next `P` (conditional add, then shift). It keeps the top-level to the FSM, counter and registers.
- The top-level instantiates `mul_step` once. No other hierarchy.

## Test plan
- Reset, then `start` with `srca`=3, `srcb`=5 → `busy` high for 32 cycles; `done` pulses once; `hi`=0, `lo`=0x0000000F.
- `srca`=0xFFFFFFFF, `srcb`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 (exercises the carry into bit 2W).
- `srca`=0x80000000, `srcb`=2 → `hi`=0x00000001, `lo`=0; then `srca`=0, `srcb`=0x1234 → `hi`=`lo`=0 after a full 32 cycles, with the previous result held during RUN.
- `start` pulsed with new operands at cycle 10 of RUN → ignored; the result equals the first operation and only one `done` pulse occurs.
- `reset` asserted at cycle 16 of RUN → `busy`, `done`, `hi`, `lo` are 0 immediately; no `done` pulse; the FSM returns to IDLE and the next `start` computes 7×6 → `lo`=42.
- `start` held high during the DONE cycle with `srca`=10, `srcb`=10 → the second operation begins at E33; its `done` pulses 33 cycles after the first `done`, with `lo`=100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the sequential multiply unit of the MIPS datapath.
package mips_pkg;

  // Operand width of the HI/LO multiplier; the product is twice this wide.
  localparam int MUL_WIDTH = 32;

  // Iteration counter must be able to hold MUL_WIDTH itself.
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH + 1);

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage : mips_pkg

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the
// upper W+1 bits of the product register, then shift the whole register
// right by one with a zero fill.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   p_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   p_out
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] upper_sum;

  // The upper field is W+1 bits wide and its top bit is always 0 before the
  // add (it was zero-filled by the previous shift), so the sum cannot
  // overflow W+1 bits and the carry survives into bit 2W.
  assign addend    = p_in[0] ? {1'b0, mcand} : '0;
  assign upper_sum = p_in[2*WIDTH:WIDTH] + addend;

  // Shifted result: zero fill on top, the new upper field, and the
  // surviving low bits moved down one place.
  assign p_out[2*WIDTH]             = 1'b0;
  assign p_out[2*WIDTH-1:WIDTH-1]   = upper_sum;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_low_shift
      assign p_out[gi] = p_in[gi + 1];
    end
  endgenerate

endmodule : mul_step

// File: rtl/multu_seq.sv
// Iterative unsigned multiplier feeding HI/LO. One partial product per
// cycle; busy stalls the PC, done acts as the HI/LO write enable.
module multu_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2*WIDTH:0] p_reg;
  logic [2*WIDTH:0] p_step;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             launch;
  logic             last_iter;

  // A new operation is accepted only outside RUN.
  assign launch    = (state_reg != RUN) && start;
  // Counter reads 1 on the edge that performs the final iteration.
  assign last_iter = (state_reg == RUN) && (cnt_reg == CNT_W'(1));

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_in  (p_reg),
    .mcand (mcand_reg),
    .p_out (p_step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: pure functions of the registered state.
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath: operand capture, iteration, and HI/LO update on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg <= '0;
      p_reg     <= '0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (launch) begin
      mcand_reg <= srca;
      p_reg     <= {{(WIDTH + 1){1'b0}}, srcb};
      cnt_reg   <= CNT_W'(WIDTH);
    end else if (state_reg == RUN) begin
      p_reg   <= p_step;
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (last_iter) begin
        hi_reg <= p_step[2*WIDTH-1:WIDTH];
        lo_reg <= p_step[WIDTH-1:0];
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule : multu_seq

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: hand-computed products, timing of busy/done,
// result hold, ignored start during RUN, async reset abort, back-to-back.
`timescale 1ns/1ps
module tb_multu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  multu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .srca  (srca),
    .srcb  (srcb),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge (E0), then drop start.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count cycles with busy high; also verify hi/lo hold their old value.
  task automatic wait_done(input logic [31:0] h_old, input logic [31:0] l_old,
                           output int nbusy, output bit held_ok);
    nbusy   = 0;
    held_ok = 1'b1;
    while (busy && nbusy < 200) begin
      if (hi !== h_old || lo !== l_old) held_ok = 1'b0;
      nbusy++;
      tick();
    end
  endtask

  // Run a full operation and check timing and result.
  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  nb;
    bit  held;
    logic [31:0] h_old, l_old;
    h_old = hi;
    l_old = lo;
    start_op(a, b);
    wait_done(h_old, l_old, nb, held);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    $display("op %s: %0h * %0h -> hi=%0h lo=%0h busy_cycles=%0d", tag, a, b, hi, lo, nb);
    tick();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int  nb;
    int  cnt;
    int  ndone;
    bit  held;
    bit  busy_seen;

    reset = 1'b1;
    start = 1'b0;
    srca  = '0;
    srcb  = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    $display("reset: busy=%0b done=%0b hi=%0h lo=%0h", busy, done, hi, lo);
    reset = 1'b0;
    tick();

    // Basic product.
    run_check("m3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
    // Carry into the top bit of the product register.
    run_check("mffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    // Product crossing into hi.
    run_check("m8000x2", 32'h80000000, 32'd2, 32'h00000001, 32'h0);
    // Zero operand still takes full latency; previous result held in RUN.
    run_check("m0x1234", 32'h0, 32'h1234, 32'h0, 32'h0);

    // start during RUN (cycle 10) is ignored.
    start_op(32'd9, 32'd11);
    cnt = 1;
    while (busy && cnt < 200) begin
      if (cnt == 10) begin
        srca  = 32'd5;
        srcb  = 32'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      cnt++;
      tick();
    end
    start = 1'b0;
    check("ign_busy_cycles", 64'(cnt - 1), 64'd32);
    check("ign_done", 64'(done), 64'd1);
    check("ign_lo", 64'(lo), 64'd99);
    ndone = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
      if (busy) busy_seen = 1'b1;
    end
    check("ign_extra_done", 64'(ndone), 64'd0);
    check("ign_no_relaunch", 64'(busy_seen), 64'd0);
    $display("op ignore: 9 * 11 -> lo=%0d extra_done=%0d", lo, ndone);

    // Async reset in the middle of RUN.
    start_op(32'd100, 32'd100);
    repeat (15) tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    tick();
    reset = 1'b0;
    ndone = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
      if (busy) busy_seen = 1'b1;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_idle", 64'(busy_seen), 64'd0);
    $display("op abort: busy=%0b done=%0b hi=%0h lo=%0h", busy, done, hi, lo);
    run_check("m7x6", 32'd7, 32'd6, 32'h0, 32'd42);

    // Back-to-back: start held in the DONE cycle.
    start_op(32'd2, 32'd3);
    wait_done(32'h0, 32'd42, nb, held);
    check("b2b_first_done", 64'(done), 64'd1);
    check("b2b_first_lo", 64'(lo), 64'd6);
    srca  = 32'd10;
    srcb  = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    check("b2b_relaunch_busy", 64'(busy), 64'd1);
    check("b2b_hold_lo", 64'(lo), 64'd6);
    while (!done && cnt < 200) begin
      tick();
      cnt++;
    end
    check("b2b_gap", 64'(cnt), 64'd33);
    check("b2b_lo", 64'(lo), 64'd100);
    check("b2b_hi", 64'(hi), 64'd0);
    $display("op b2b: 10 * 10 -> lo=%0d done_gap=%0d", lo, cnt);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multu_seq
